ram_port_arbiter: RTL

Shares one single-port RAM (synchronous write, asynchronous read) between two requesters: instruction fetch (port A, read-only) and data load/store (port B, read/write).
- Grants at most one access per cycle and drives the RAM address, data and write-enable.
- Registers read data with fixed 1-cycle latency.
- Prevents fetch starvation with a bounded-wait counter.
- Sits between the CPU core and the RAM instance inside the cpu top level.

---
 rtl/cpu_mem_pkg.sv | 25 ++
 rtl/ram_port_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/cpu_mem_pkg.sv
// ============================================================================
// Module : cpu_mem_pkg
// Brief  : Constants shared by the CPU memory subsystem. This covers the
//          default RAM geometry, the fetch starvation bound and the
//          requester identifiers used by assertions and debug.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

  // Default geometry shared with the RAM instance in the cpu top level
  localparam int DEFAULT_D_BITS = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Consecutive denied fetch cycles before fetch overrides data priority
  localparam int MAX_WAIT_DEFAULT = 3;

  // Requester identifiers
  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_DATA   = 1'b1;

endpackage : cpu_mem_pkg

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module : ram_port_arbiter
// Brief  : Shares one single-port RAM (synchronous write, asynchronous read)
//          between the instruction fetch port (A, read-only) and the data
//          port (B, read/write). At most one access is granted per cycle.
//          B has default priority. A bounded-wait counter guarantees that a
//          fetch is granted within MAX_WAIT+1 cycles. Read data is
//          registered, so reads have a fixed latency of one cycle.
// Ports  : clk, rst_n             clock, async active-low reset
//          a_req/a_addr           fetch request and address
//          a_ready                fetch granted this cycle (combinational)
//          a_rdata/a_rvalid       fetch read data, 1-cycle valid pulse
//          b_req/b_we/b_addr/     data request, write enable, address,
//          b_wdata                write data
//          b_ready                data granted this cycle (combinational)
//          b_rdata/b_rvalid       data read data, 1-cycle valid pulse
//          ram_addr/ram_din/      RAM address, write data, write enable
//          ram_we
//          ram_dout               RAM asynchronous read data
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int D_BITS   = DEFAULT_D_BITS,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A: instruction fetch
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ready,
  output logic [D_BITS-1:0] a_rdata,
  output logic              a_rvalid,
  // port B: data load/store
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [D_BITS-1:0] b_wdata,
  output logic              b_ready,
  output logic [D_BITS-1:0] b_rdata,
  output logic              b_rvalid,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [D_BITS-1:0] ram_din,
  output logic              ram_we,
  input  logic [D_BITS-1:0] ram_dout
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic [3:0] r_wait_cnt;
  logic       w_a_win;
  logic       w_grant_id;

  // Fetch wins when data is idle, or when it has already waited MAX_WAIT
  // cycles. Both grants are gated by rst_n, so that no RAM write can
  // occur while reset is held.
  assign w_a_win  = !b_req || (r_wait_cnt == c_max_wait);
  assign a_ready  = rst_n && a_req && w_a_win;
  assign b_ready  = rst_n && b_req && !a_ready;

  assign ram_addr = b_ready ? b_addr : a_addr;
  assign ram_we   = b_ready && b_we;
  assign ram_din  = b_wdata;

  assign w_grant_id = b_ready ? REQ_DATA : REQ_IFETCH;

  // Starvation counter. It counts consecutive cycles in which the fetch
  // port is denied. A dropped request clears it, because requests are
  // never queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (a_req && !a_ready) begin
      if (r_wait_cnt != c_max_wait)
        r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Read-data registers. A valid pulse lasts for one cycle per granted
  // read, so back-to-back grants keep it high. The data holds between
  // reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_ready;
      if (a_ready)
        a_rdata <= ram_dout;
      b_rvalid <= b_ready && !b_we;
      if (b_ready && !b_we)
        b_rdata <= ram_dout;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(a_ready && b_ready));
      assert (!ram_we || (w_grant_id == REQ_DATA));
      assert (r_wait_cnt <= c_max_wait);
    end
  end
`endif

endmodule : ram_port_arbiter

`default_nettype wire
